// File: rtl/ysyx_22050243_mem_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050243_mem_pkg
// Shared definitions for the data-memory slave and future cache/bus blocks:
//   - mem_state_t       : responder FSM states (IDLE, WAIT, RESP)
//   - DEFAULT_ADDR_BASE : byte address that maps to word 0 of data memory
//   - mask_merge()      : per-bit masked update of a 64-bit word
// ---------------------------------------------------------------------------
package ysyx_22050243_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic [63:0] DEFAULT_ADDR_BASE = 64'h0000_0000_8000_0000;

    // Bits with mask=1 take the new data; bits with mask=0 keep the old word.
    function automatic logic [63:0] mask_merge(
        input logic [63:0] old_word,
        input logic [63:0] data,
        input logic [63:0] mask
    );
        return (old_word & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/ysyx_22050243_sram_array.sv
// ---------------------------------------------------------------------------
// ysyx_22050243_sram_array
// DEPTH_WORDS x 64-bit storage, no reset.
//   clk      : clock
//   rd_idx   : read word index, sampled every cycle
//   rd_data  : registered read data (value of mem[rd_idx] at the last edge,
//              taken before any write on that same edge)
//   wr_en    : commit a masked write on this edge
//   wr_idx   : write word index
//   wr_data  : write data
//   wr_mask  : per-bit write enable
// ---------------------------------------------------------------------------
module ysyx_22050243_sram_array
    import ysyx_22050243_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_idx,
    output logic [63:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [63:0]   wr_data,
    input  logic [63:0]   wr_mask
);

    logic [63:0] mem [DEPTH_WORDS];
    logic [63:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= mask_merge(mem[wr_idx], wr_data, wr_mask);
        end
        rd_data_reg <= mem[rd_idx];
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/ysyx_22050243_dmem_slave.sv
// ---------------------------------------------------------------------------
// ysyx_22050243_dmem_slave
// Data-memory responder: accepts one 64-bit request at a time (read or
// bit-masked write), waits LATENCY cycles, then strobes the response.
//   clk, rst     : clock, synchronous active-high reset
//   ram_addr     : byte address (bits [2:0] ignored)
//   ram_r_en     : read request
//   ram_w_en     : write request
//   ram_wmask    : per-bit write enable
//   ram_w_data   : lane-aligned write data
//   ram_ready    : request can be accepted this cycle
//   ram_r_data   : read data, holds its value outside a read response
//   ram_r_valid  : one-cycle strobe, ram_r_data valid
//   ram_err      : one-cycle strobe, response is an error
// Errors (out of range, or read and write both high) suppress the memory
// write; an erroneous read still pulses ram_r_valid with zero data.
// ---------------------------------------------------------------------------
module ysyx_22050243_dmem_slave
    import ysyx_22050243_mem_pkg::*;
#(
    parameter logic [63:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] ram_addr,
    input  logic        ram_r_en,
    input  logic        ram_w_en,
    input  logic [63:0] ram_wmask,
    input  logic [63:0] ram_w_data,
    output logic        ram_ready,
    output logic [63:0] ram_r_data,
    output logic        ram_r_valid,
    output logic        ram_err
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

    mem_state_t    state_reg;
    logic [3:0]    cnt_reg;
    logic [AW-1:0] idx_reg;
    logic [63:0]   wmask_reg;
    logic [63:0]   w_data_reg;
    logic          rd_op_reg;
    logic          wr_op_reg;
    logic          err_reg;
    logic          ready_reg;
    logic          r_valid_reg;
    logic          err_out_reg;
    logic [63:0]   r_data_hold_reg;

    // Incoming request decode
    logic [63:0]   offset;
    logic [AW-1:0] req_idx;
    logic          req_in_range;
    logic          req_err;
    logic          accept;

    assign offset       = ram_addr - ADDR_BASE;
    assign req_in_range = (ram_addr >= ADDR_BASE) && ((offset >> 3) < 64'(DEPTH_WORDS));
    assign req_idx      = offset[AW+2:3];
    assign req_err      = !req_in_range || (ram_r_en && ram_w_en);
    assign accept       = (ram_r_en || ram_w_en) && ready_reg;

    // With LATENCY == 1 the response edge is the acceptance edge, so the
    // memory port must see the live request; otherwise it sees the latched one.
    logic          use_live;
    logic [AW-1:0] cur_idx;
    logic [63:0]   cur_mask;
    logic [63:0]   cur_data;
    logic          cur_rd;
    logic          cur_wr;
    logic          cur_err;

    assign use_live = (state_reg == IDLE);
    assign cur_idx  = use_live ? req_idx    : idx_reg;
    assign cur_mask = use_live ? ram_wmask  : wmask_reg;
    assign cur_data = use_live ? ram_w_data : w_data_reg;
    assign cur_rd   = use_live ? ram_r_en   : rd_op_reg;
    assign cur_wr   = use_live ? ram_w_en   : wr_op_reg;
    assign cur_err  = use_live ? req_err    : err_reg;

    // High in the cycle whose closing edge moves the FSM into RESP
    logic enter_resp;
    always_comb begin
        enter_resp = 1'b0;
        case (state_reg)
            IDLE:    enter_resp = accept && (LATENCY == 1);
            WAIT:    enter_resp = (cnt_reg == 4'd1);
            default: enter_resp = 1'b0;
        endcase
    end

    logic        wr_commit;
    logic [63:0] sram_rd_data;

    assign wr_commit = enter_resp && !rst && cur_wr && !cur_err;

    ysyx_22050243_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk     (clk),
        .rd_idx  (cur_idx),
        .rd_data (sram_rd_data),
        .wr_en   (wr_commit),
        .wr_idx  (cur_idx),
        .wr_data (cur_data),
        .wr_mask (cur_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= 4'd0;
            idx_reg         <= '0;
            wmask_reg       <= 64'd0;
            w_data_reg      <= 64'd0;
            rd_op_reg       <= 1'b0;
            wr_op_reg       <= 1'b0;
            err_reg         <= 1'b0;
            ready_reg       <= 1'b0;
            r_valid_reg     <= 1'b0;
            err_out_reg     <= 1'b0;
            r_data_hold_reg <= 64'd0;
        end else begin
            r_valid_reg     <= 1'b0;
            err_out_reg     <= 1'b0;
            r_data_hold_reg <= ram_r_data;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        idx_reg    <= req_idx;
                        wmask_reg  <= ram_wmask;
                        w_data_reg <= ram_w_data;
                        rd_op_reg  <= ram_r_en;
                        wr_op_reg  <= ram_w_en;
                        err_reg    <= req_err;
                        ready_reg  <= 1'b0;
                        if (LATENCY == 1) begin
                            state_reg <= RESP;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= WAIT_LOAD;
                        end
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b0;
                end
            endcase
            if (enter_resp) begin
                // A read-and-write collision is an error with no valid strobe
                r_valid_reg <= cur_rd && !cur_wr;
                err_out_reg <= cur_err;
            end
        end
    end

    assign ram_ready   = ready_reg;
    assign ram_r_valid = r_valid_reg;
    assign ram_err     = err_out_reg;
    // Read data is live from the array only in a read response; otherwise the
    // previous output is replayed so the bus sees a stable value.
    assign ram_r_data  = r_valid_reg ? (err_out_reg ? 64'd0 : sram_rd_data)
                                     : r_data_hold_reg;

endmodule

// File: doc/ysyx_22050243_dmem_slave.md
# ysyx_22050243_dmem_slave

Data-memory responder on the RAM side of the CPU memory controller. Accepts one 64-bit word request at a time (read, or bit-masked write), models a configurable access latency, and returns read data with a valid strobe. Used as the simulation and FPGA data memory behind the controller's lane-steered `ram_*` port.

## Interface
- `ADDR_BASE`, default 64'h0000_0000_8000_0000: byte address of word 0.
- `DEPTH_WORDS`, default 1024: number of 64-bit words (power of two).
- `LATENCY`, default 1: cycles from request acceptance to response; legal range 1..15.

- `clk`  in  1: clock, all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `ram_addr`  in  64: byte address; bits [2:0] ignored.
- `ram_r_en`  in  1: read request.
- `ram_w_en`  in  1: write request.
- `ram_wmask`  in  64: per-bit write enable.
- `ram_w_data`  in  64: write data, already lane-aligned.
- `ram_ready`  out  1: slave can accept a request this cycle.
- `ram_r_data`  out  64: read data.
- `ram_r_valid`  out  1: one-cycle strobe, `ram_r_data` is valid.
- `ram_err`  out  1: one-cycle strobe, the current response is an error.

## Operation
- A request is accepted in a cycle where `(ram_r_en | ram_w_en) & ram_ready`. On acceptance, the block latches addr, wmask, w_data, and op.
- Word index is `(ram_addr - ADDR_BASE) >> 3`. The request is in range iff `ram_addr >= ADDR_BASE` and index `< DEPTH_WORDS`.
- The FSM has three states:
  - IDLE -> WAIT on acceptance when LATENCY > 1; IDLE -> RESP when LATENCY == 1.
  - WAIT: a 4-bit counter loaded with LATENCY-1 and decremented each cycle. WAIT -> RESP when the counter reaches 1.
  - RESP -> IDLE unconditionally.
- Write commit happens on the RESP-entry edge: `mem[idx] <= (mem[idx] & ~wmask) | (w_data & wmask)`. Bits with mask 0 are unchanged. A wmask of all zero is a legal no-op.
- Read response: in RESP, `ram_r_valid` = 1 and `ram_r_data` = `mem[idx]`. A write with a zero-masked bit reads back the old bit.
- Errors: an out-of-range request, or `ram_r_en & ram_w_en` both high, produces these effects in RESP:
  - `ram_err` = 1.
  - No memory write.
  - A read still pulses `ram_r_valid`, with data 0.
  - A both-high request pulses `ram_r_valid` = 0.
- `ram_r_data` holds its last value outside RESP. It changes only in a read RESP.
- Requests while `ram_ready` = 0 are ignored, not queued. The master must hold or re-present them.

## Timing
- While `rst` is high, and in the cycle after: state IDLE, `ram_ready` = 0 during rst, `ram_r_valid` = 0, `ram_err` = 0, `ram_r_data` = 0, counter = 0. `ram_ready` = 1 from the first cycle after rst deasserts.
- Memory contents are not reset.
- For a request accepted at edge T:
  - Response strobes are visible in cycle T+LATENCY.
  - Write data is readable by a request accepted at T+LATENCY+1 or later.
  - `ram_ready` rises again in cycle T+LATENCY+1.
- Maximum throughput is one request per LATENCY+1 cycles.
- `ram_ready` is a registered function of state (state == IDLE && !rst). There is no combinational path from any input to any output.
- Reset mid-operation (in WAIT or RESP) abandons the request. A pending write is not committed and no strobe is issued.
- Back-to-back read then write to the same word: the read returns the pre-write value.

## Structure
- Package `ysyx_22050243_mem_pkg` holds:
  - The state enum (IDLE, WAIT, RESP).
  - The default `ADDR_BASE` constant.
  - A `mask_merge(old, data, mask)` function, shared with future cache/bus blocks.
- Sub-module `ysyx_22050243_sram_array` holds DEPTH_WORDS x 64-bit storage, with one synchronous read port and one bit-masked write port. It contains no reset. The FSM, latching, and range check stay in the top module.

## Test plan
- LATENCY=1: write 0x1122334455667788 full mask to 0x8000_0010, then read 0x8000_0010 -> `ram_r_valid` at T+1 with that data; `ram_ready` low exactly 1 cycle after each accept.
- Partial write: mask 0x0000_0000_FF00_0000, data 0x0000_0000_AB00_0000 over word 0x1122334455667788 -> readback 0x11223344AB667788.
- LATENCY=4: request held from cycle 0 -> response at cycle 4, ready at 5; a second request presented in cycles 1..4 is not accepted until cycle 5.
- Out-of-range: read 0x7FFF_FFF8 and 0x8000_2000 (DEPTH 1024) -> `ram_err` = 1, `ram_r_valid` = 1, data 0. A write to 0x8000_2000 leaves word 0 unchanged.
- Both `ram_r_en` and `ram_w_en` high -> `ram_err` = 1, `ram_r_valid` = 0, memory unchanged.
- Assert `rst` during WAIT of a write (LATENCY=3) -> no strobe, the word retains its old value, `ram_ready` = 1 the cycle after rst drops.
